// File: rtl/dpram64_pkg.sv
// rtl/dpram64_pkg.sv - shared sizes for the 64-deep distributed-RAM FIFO
package dpram64_pkg;
    localparam int DEPTH   = 64;
    localparam int PTR_W   = 6;
    localparam int CNT_W   = 7;
    localparam int LEVEL_W = 7;

    localparam logic [CNT_W-1:0] RAM_FULL_CNT = CNT_W'(DEPTH);
endpackage

// File: rtl/dpram64xw.sv
// rtl/dpram64xw.sv - WIDTH-bit wide bank of 64x1 dual-port RAMs
module dpram64xw
    import dpram64_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_addr,
    input  logic [PTR_W-1:0] i_dpra,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_dpo
);
    localparam logic [63:0] RAM_INIT = INIT_ZERO ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;

    // The single-port read output follows the write address and has no consumer here.
    logic [WIDTH-1:0] w_spo_unused;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        RAM64X1D #(
            .INIT (RAM_INIT)
        ) u_ram (
            .DPO   (o_dpo[g]),
            .SPO   (w_spo_unused[g]),
            .A0    (i_addr[0]),
            .A1    (i_addr[1]),
            .A2    (i_addr[2]),
            .A3    (i_addr[3]),
            .A4    (i_addr[4]),
            .A5    (i_addr[5]),
            .D     (i_d[g]),
            .DPRA0 (i_dpra[0]),
            .DPRA1 (i_dpra[1]),
            .DPRA2 (i_dpra[2]),
            .DPRA3 (i_dpra[3]),
            .DPRA4 (i_dpra[4]),
            .DPRA5 (i_dpra[5]),
            .WCLK  (i_clk),
            .WE    (i_we)
        );
    end
endmodule

// File: rtl/ram64x1d.sv
// rtl/ram64x1d.sv - behavioral model of the 64x1 dual-port distributed RAM primitive
module RAM64X1D #(
    parameter logic [63:0] INIT = 64'h0
) (
    output logic DPO,
    output logic SPO,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic D,
    input  logic DPRA0,
    input  logic DPRA1,
    input  logic DPRA2,
    input  logic DPRA3,
    input  logic DPRA4,
    input  logic DPRA5,
    input  logic WCLK,
    input  logic WE
);
    logic [63:0] r_mem = INIT;
    logic [5:0]  w_a;
    logic [5:0]  w_dpra;

    assign w_a    = {A5, A4, A3, A2, A1, A0};
    assign w_dpra = {DPRA5, DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};

    always @(posedge WCLK) begin
        if (WE) begin
            r_mem[w_a] <= D;
        end
    end

    // Both read ports are asynchronous.
    assign SPO = r_mem[w_a];
    assign DPO = r_mem[w_dpra];
endmodule

// File: rtl/dpram64_fifo_ctrl.sv
// rtl/dpram64_fifo_ctrl.sv - first-word-fall-through FIFO built on a 64-deep distributed RAM bank
module dpram64_fifo_ctrl
    import dpram64_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_ram_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic             w_wr_fire;
    logic             w_load;
    logic [WIDTH-1:0] w_dpo;

    dpram64xw #(
        .WIDTH     (WIDTH),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .i_clk  (clk),
        .i_we   (w_wr_fire),
        .i_addr (r_wr_ptr),
        .i_dpra (r_rd_ptr),
        .i_d    (in_data),
        .o_dpo  (w_dpo)
    );

    // in_ready comes from registered state only, so no out_ready -> in_ready path exists.
    assign in_ready  = (r_ram_cnt != RAM_FULL_CNT);
    assign w_wr_fire = in_valid & in_ready;
    assign w_load    = (r_ram_cnt != '0) & (~r_out_valid | out_ready);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_load) begin
                r_out_data  <= w_dpo;
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_ram_cnt <= r_ram_cnt + CNT_W'(w_wr_fire) - CNT_W'(w_load);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign level     = r_ram_cnt + LEVEL_W'(r_out_valid);
    assign full      = ~in_ready;
    assign empty     = ~r_out_valid;
endmodule

// File: tb/tb_dpram64_fifo_ctrl.sv
// tb/tb_dpram64_fifo_ctrl.sv - directed and scoreboard bench for dpram64_fifo_ctrl
module tb_dpram64_fifo_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       level;
    logic             full;
    logic             empty;

    int n_vec  = 0;
    int n_miss = 0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    dpram64_fifo_ctrl #(
        .WIDTH     (WIDTH),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_traffic(input int n_words, input int pct, input bit seq_data,
                               input int max_cyc, output int reads, output int cycles);
        int   writes;
        logic rdy_a;
        writes = 0;
        reads  = 0;
        cycles = 0;
        while (cycles < max_cyc && (writes < n_words || sb_q.size() != 0)) begin
            in_valid  = (writes < n_words) && ($urandom_range(99) < pct);
            in_data   = seq_data ? WIDTH'(writes) : WIDTH'($urandom);
            out_ready = ($urandom_range(99) < pct);
            #1;
            rdy_a     = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("in_ready_indep_out_ready", {31'b0, in_ready}, {31'b0, rdy_a});
            out_ready = ~out_ready;
            #1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                else chk("sb_data", {24'b0, out_data}, {24'b0, sb_q.pop_front()});
                reads++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                writes++;
            end
            tick();
            cycles++;
            chk("sb_level", {25'b0, level}, sb_q.size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("traffic_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int cycles;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_level", {25'b0, level}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'h00);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);

        // single write, two-cycle latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("lat_c1_out_valid", {31'b0, out_valid}, 32'd0);
        chk("lat_c1_level", {25'b0, level}, 32'd1);
        tick();
        chk("lat_c2_out_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_c2_out_data", {24'b0, out_data}, 32'hA5);
        chk("lat_c2_level", {25'b0, level}, 32'd1);
        tick();
        chk("lat_c3_level", {25'b0, level}, 32'd1);
        chk("lat_c3_out_data", {24'b0, out_data}, 32'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_drain_empty", {31'b0, empty}, 32'd1);
        chk("lat_drain_level", {25'b0, level}, 32'd0);
        chk("stale_out_data", {24'b0, out_data}, 32'hA5);

        // fill to 65, then one dropped write
        for (int i = 0; i < 65; i++) begin
            chk("fill_in_ready", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            tick();
        end
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("full_flag", {31'b0, full}, 32'd1);
        chk("full_level", {25'b0, level}, 32'd65);
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        chk("drop_level", {25'b0, level}, 32'd65);
        out_ready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_data", {24'b0, out_data}, i);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", {31'b0, empty}, 32'd1);
        chk("drain_level", {25'b0, level}, 32'd0);

        // sustained streaming: 200 words in 202 cycles with pointer wrap
        run_traffic(200, 100, 1'b1, 400, reads, cycles);
        chk("stream_reads", reads, 32'd200);
        chk("stream_cycles", cycles, 32'd202);

        // random handshakes at 50% duty
        run_traffic(1000, 50, 1'b0, 20000, reads, cycles);
        chk("random_reads", reads, 32'd1000);

        // reset mid-stream at level 30
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(8'h80 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_rst_level", {25'b0, level}, 32'd30);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_level", {25'b0, level}, 32'd0);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_out_data", {24'b0, out_data}, 32'h3C);
        chk("post_rst_level", {25'b0, level}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dpram64_fifo_ctrl.md
# dpram64_fifo_ctrl

Sequencer that turns a bank of 64-deep distributed dual-port RAM primitives (the RAM64X1D family, one primitive per data bit) into a synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the write port (A0–A5, D, WE) and the dual read address (DPRA0–DPRA5), and registers the asynchronous DPO output. It sits between the KCPSM3 port interface and peripheral logic as the standard shallow buffer.

## Interface
Parameters:
- WIDTH, 8, data width; one RAM64X1D per bit.
- INIT_ZERO, 1, when 1 the RAM INIT parameters are all zero; content is never relied on before a write.

Ports:
- clk  in  1  single clock; RAM WCLK tied to clk (positive-edge RAM64X1D, not the _1 variant).
- reset_n  in  1  reset, synchronous and active-low.
- in_data  in  WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  space available in RAM.
- out_data  out  WIDTH  registered head-of-queue data.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data.
- level  out  7  total words held (RAM plus output register), 0..65.
- full  out  1  equals !in_ready.
- empty  out  1  equals !out_valid.

## Operation
- Registers: wr_ptr[5:0], rd_ptr[5:0], ram_cnt[6:0] (0..64), out_data, out_valid.
- Write: wr_fire = in_valid & in_ready. RAM WE = wr_fire, A = wr_ptr, D = in_data. On wr_fire, wr_ptr wraps 63 -> 0.
- in_ready = (ram_cnt != 64). It depends only on registered state; there is no combinational path from out_ready.
- Read: DPRA = rd_ptr always. load = (ram_cnt != 0) & (!out_valid | out_ready). On load, out_data <= DPO, rd_ptr increments and wraps, and out_valid <= 1.
- Consume without reload: out_valid & out_ready & !load -> out_valid <= 0; out_data holds its stale value.
- ram_cnt next = ram_cnt + wr_fire - load. Simultaneous write and load leaves it unchanged.
- A write is never bypassed to the output. A word written on edge k is readable via DPRA only from cycle k+1.
- Same-address write and read in one cycle cannot occur, because a load needs ram_cnt != 0 and wr_ptr == rd_ptr then implies ram_cnt == 64.
- level = ram_cnt + out_valid, 7-bit unsigned, maximum 65.
- No state machine beyond the counters. The FIFO state is fully encoded by ram_cnt and out_valid.

## Timing
- Reset (reset_n low at a rising edge): wr_ptr = rd_ptr = 0, ram_cnt = 0, out_valid = 0, out_data = 0.
  - Outputs after reset: in_ready = 1, full = 0, empty = 1, level = 0.
  - RAM contents are untouched. Reset overrides wr_fire and load in the same edge.
- Latency on an empty FIFO: in_valid accepted at edge k, out_valid high after edge k+1 (two cycles).
- Throughput: one write and one read per cycle sustained.
- Full: level = 65, in_ready = 0. in_valid is ignored and the RAM is not written.
- Empty: out_valid = 0. out_ready is ignored.
- Reset mid-stream discards all contents. The next written word is the next word out.
- in_data must be stable only at the edge where wr_fire = 1. out_data changes only on load or reset.

## Structure
- Package dpram64_pkg: DEPTH = 64, PTR_W = 6, CNT_W = 7, LEVEL_W = 7.
- Sub-module dpram64xw: a generate loop of WIDTH RAM64X1D instances with shared A, DPRA and WE, per-bit D/DPO, and unused SPO.
- The controller contains only pointers, counters and the output register.

## Test plan
- Reset then idle -> in_ready = 1, out_valid = 0, level = 0, out_data = 0x00.
- Single write of 0xA5 at cycle 0 with out_ready held 0 -> out_valid = 1 and out_data = 0xA5 from cycle 2; level = 1 and remains 1.
- Write 65 words 0x00..0x40 with out_ready = 0 -> in_ready falls after the 65th accept, full = 1, level = 65. A 66th write attempt is dropped. Draining yields 0x00..0x40 in order, then empty = 1.
- Continuous writes and reads for 200 words with both handshakes held high -> one word per cycle out, values in order, with pointer wrap past 63 and at least one data value sitting at each address.
- Random in_valid/out_ready at 50% duty over 1000 words -> scoreboard match, level never exceeds 65, and in_ready never depends on same-cycle out_ready.
- reset_n pulsed low for one cycle with level = 30 -> level = 0 and out_valid = 0 the next cycle. A subsequent write of 0x3C is the first word output.
